// File: rtl/cntr8_pkg.sv
// Shared types for the cntr8 stimulus driver: FSM states, command op codes and data width.
package cntr8_pkg;

   localparam int DW = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_UP      = 2'b01,
      OP_DOWN    = 2'b10,
      OP_LOAD_UP = 2'b11
   } op_t;

   function automatic logic op_has_load(input op_t op);
      return (op == OP_LOAD) || (op == OP_LOAD_UP);
   endfunction

endpackage

// File: rtl/cntr8_drv_chk.sv
// Shadow count of the cntr8 value plus a CHK_LAT-deep (expected, valid) pipeline compared
// against the returned count; any mismatch sets a sticky error until reset.
module cntr8_drv_chk
   import cntr8_pkg::*;
#(
   parameter int CHK_LAT = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          active,
   input  logic          load,
   input  logic          inc,
   input  logic [DW-1:0] d_in,
   input  logic [DW-1:0] cnt_in,
   output logic          chk_err
);

   logic [DW-1:0]      shadow;
   logic [DW-1:0]      shadow_next;
   logic [DW-1:0]      exp_pipe [CHK_LAT];
   logic [CHK_LAT-1:0] vld_pipe;

   // Only driven cycles move the shadow; on RUN, inc=0 means a down step.
   always_comb begin
      shadow_next = shadow;
      if (active) begin
         if (load)
            shadow_next = d_in;
         else if (inc)
            shadow_next = shadow + 8'd1;
         else
            shadow_next = shadow - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow   <= '0;
         vld_pipe <= '0;
         for (int i = 0; i < CHK_LAT; i++)
            exp_pipe[i] <= '0;
      end else begin
         shadow      <= shadow_next;
         exp_pipe[0] <= shadow_next;
         vld_pipe[0] <= active;
         for (int i = 1; i < CHK_LAT; i++) begin
            exp_pipe[i] <= exp_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         chk_err <= 1'b0;
      else if (vld_pipe[CHK_LAT-1] && (exp_pipe[CHK_LAT-1] != cnt_in))
         chk_err <= 1'b1;
   end

endmodule

// File: rtl/cntr8_drv.sv
// Command-driven load/inc sequencer for cntr8 with handshake and done pulse.
// Optional returned-count checking is enabled by defining CNTR8_DRV_CHECK_EN.
module cntr8_drv
   import cntr8_pkg::*;
#(
   parameter int CHK_LAT = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   input  logic [DW-1:0] cmd_len,
   output logic          load,
   output logic          inc,
   output logic [DW-1:0] d_in,
   output logic          busy,
   output logic          done,
   input  logic [DW-1:0] cnt_in,
   output logic          chk_err
);

   state_t        state;
   op_t           op_reg;
   logic [DW-1:0] step;
   op_t           new_op;

   assign new_op = op_t'(cmd_op);

   // Outputs are assigned alongside the state they belong to, so they are registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         op_reg    <= OP_LOAD;
         step      <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         load      <= 1'b0;
         inc       <= 1'b0;
         d_in      <= '0;
      end else begin
         load <= 1'b0;
         inc  <= 1'b0;
         d_in <= '0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_reg    <= new_op;
                  step      <= cmd_len;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (op_has_load(new_op)) begin
                     state <= S_LOAD;
                     load  <= 1'b1;
                     d_in  <= cmd_data;
                  end else if (cmd_len != '0) begin
                     state <= S_RUN;
                     inc   <= (new_op == OP_UP);
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if ((op_reg == OP_LOAD_UP) && (step != '0)) begin
                  state <= S_RUN;
                  inc   <= 1'b1;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_RUN: begin
               step <= step - 8'd1;
               if (step == 8'd1) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  inc <= (op_reg != OP_DOWN);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef CNTR8_DRV_CHECK_EN
   cntr8_drv_chk #(
      .CHK_LAT (CHK_LAT)
   ) u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .active  ((state == S_LOAD) || (state == S_RUN)),
      .load    (load),
      .inc     (inc),
      .d_in    (d_in),
      .cnt_in  (cnt_in),
      .chk_err (chk_err)
   );
`else
   logic unused_cnt_in;
   assign unused_cnt_in = ^cnt_in;
   assign chk_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cntr8_drv.sv
// Randomized + directed bench for cntr8_drv: per-cycle trace model, counter stand-in, timing pins.
module tb_cntr8_drv;
   import cntr8_pkg::*;

   localparam int CHK_LAT = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic [7:0] cmd_len = 8'h00;
   logic       cmd_ready, load, inc, busy, done, chk_err;
   logic [7:0] d_in, cnt_in;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cntr8_drv #(.CHK_LAT(CHK_LAT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .load      (load),
      .inc       (inc),
      .d_in      (d_in),
      .busy      (busy),
      .done      (done),
      .cnt_in    (cnt_in),
      .chk_err   (chk_err)
   );

   // Stand-in for cntr8: moves only while the driver is driving it.
   logic [7:0] cnt;
   logic       cnt_fault = 1'b0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)             cnt <= 8'h00;
      else if (load)            cnt <= d_in;
      else if (inc)             cnt <= cnt + 8'd1;
      else if (busy && !done)   cnt <= cnt - 8'd1;
   end
   assign cnt_in = cnt ^ {7'd0, cnt_fault};

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected per-cycle trace of a command, from the handshake rules.
   typedef struct packed {
      logic       load;
      logic       inc;
      logic [7:0] d;
      logic       done;
   } exp_t;
   exp_t q[$];

   function automatic void push_cmd(input logic [1:0] op, input logic [7:0] data,
                                    input logic [7:0] len);
      exp_t e;
      if (op == 2'b00 || op == 2'b11) begin
         e = '0; e.load = 1'b1; e.d = data; q.push_back(e);
      end
      if (op != 2'b00) begin
         for (int i = 0; i < int'(len); i++) begin
            e = '0; e.inc = (op != 2'b10); q.push_back(e);
         end
      end
      e = '0; e.done = 1'b1; q.push_back(e);
   endfunction

   int cyc = 0;
   int hs_count = 0;
   int hs_edge = 0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset_n !== 1'b1) q.delete();
      else if (cmd_valid && cmd_ready === 1'b1) begin
         hs_count = hs_count + 1;
         hs_edge  = cyc;
         push_cmd(cmd_op, cmd_data, cmd_len);
      end
   end

   logic chk_exp = 1'b0;
   logic chk_skip = 1'b0;
   int done_cyc = 0;
   int done_cnt = 0;
   int load_cnt = 0;
   int inc_cnt = 0;
   always @(negedge clk) begin : compare
      exp_t e;
      logic e_busy;
      if (reset_n === 1'b1) begin
         if (q.size() > 0) begin e = q.pop_front(); e_busy = 1'b1; end
         else begin e = '0; e_busy = 1'b0; end
         chk1("load", load, e.load);
         chk1("inc", inc, e.inc);
         chk8("d_in", d_in, e.d);
         chk1("done", done, e.done);
         chk1("busy", busy, e_busy);
         chk1("cmd_ready", cmd_ready, !e_busy);
         if (!chk_skip) chk1("chk_err", chk_err, chk_exp);
         if (done === 1'b1) begin done_cyc = cyc + 1; done_cnt++; end
         if (load === 1'b1) load_cnt++;
         if (inc === 1'b1) inc_cnt++;
      end
   end

   task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len,
                       input bit keep);
      int  h0;
      bit  got;
      h0  = hs_count;
      got = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (hs_count != h0) begin got = 1; break; end
      end
      if (!keep) cmd_valid = 1'b0;
      chki("handshake_seen", int'(got), 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (q.size() == 0 && cmd_ready === 1'b1) begin ok = 1; break; end
      end
      chki("idle_reached", int'(ok), 1);
   endtask

   logic [7:0] exp_cnt = 8'h00;

   // One full command: check done latency, single done pulse and the resulting count.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len);
      int d0, lat;
      d0 = done_cnt;
      if (op == 2'b00)      lat = 2;
      else if (op == 2'b11) lat = int'(len) + 2;
      else                  lat = int'(len) + 1;
      if (op == 2'b00 || op == 2'b11) exp_cnt = data;
      if (op == 2'b01 || op == 2'b11) exp_cnt = exp_cnt + len;
      if (op == 2'b10)                exp_cnt = exp_cnt - len;
      send(op, data, len, 0);
      wait_idle();
      chki("done_latency", done_cyc - hs_edge, lat);
      chki("done_pulses", done_cnt - d0, 1);
      chk8("count", cnt_in, exp_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, i0, h1, dc;
      logic [1:0] r_op;
      logic [7:0] r_data, r_len;

      #1 reset_n = 1'b0;
      #2;
      chk1("rst_cmd_ready", cmd_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_load", load, 1'b0);
      chk1("rst_inc", inc, 1'b0);
      chk8("rst_d_in", d_in, 8'h00);
      chk1("rst_chk_err", chk_err, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // LOAD 5A: one load cycle, done next cycle
      l0 = load_cnt;
      run_cmd(2'b00, 8'h5A, 8'd7);
      chki("load_cycles", load_cnt - l0, 1);
      chk8("cnt_5a", cnt_in, 8'h5A);

      // LOAD_UP FE len 3: wraps to 01, done at k+5
      i0 = inc_cnt;
      run_cmd(2'b11, 8'hFE, 8'd3);
      chki("loadup_incs", inc_cnt - i0, 3);
      chk8("cnt_wrap_up", cnt_in, 8'h01);
      chk1("chk_err_clean", chk_err, 1'b0);

      // DOWN len 0: done at k+1, no activity
      l0 = load_cnt; i0 = inc_cnt;
      run_cmd(2'b10, 8'hC3, 8'd0);
      chki("len0_loads", load_cnt - l0, 0);
      chki("len0_incs", inc_cnt - i0, 0);
      chk8("cnt_len0", cnt_in, 8'h01);

      // Wrap down: 00 then one down step
      run_cmd(2'b00, 8'h00, 8'd0);
      run_cmd(2'b10, 8'h00, 8'd1);
      chk8("cnt_wrap_down", cnt_in, 8'hFF);

      // Back-to-back with cmd_valid held: second handshake only after done + idle
      send(2'b01, 8'h00, 8'd2, 1);
      h1 = hs_edge;
      send(2'b10, 8'h00, 8'd2, 0);
      chki("b2b_hs_gap", hs_edge - h1, 4);
      wait_idle();
      chk8("cnt_b2b", cnt_in, exp_cnt);

      // Longest command
      run_cmd(2'b11, 8'h00, 8'd255);
      chk8("cnt_len255", cnt_in, 8'hFF);

      for (int n = 0; n < 40; n++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_data = 8'($urandom);
         r_len  = 8'($urandom_range(0, 9));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_cmd(r_op, r_data, r_len);
      end

      // Reset mid-RUN at step 4 of UP len 10
      dc = done_cnt;
      send(2'b01, 8'h00, 8'd10, 0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk1("midrst_inc", inc, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_cmd_ready", cmd_ready, 1'b1);
      chk1("midrst_done", done, 1'b0);
      chk8("midrst_d_in", d_in, 8'h00);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_cnt = 8'h00;
      repeat (3) @(negedge clk);
      chki("midrst_no_done", done_cnt - dc, 0);
      chk1("midrst_ready_after", cmd_ready, 1'b1);

`ifdef CNTR8_DRV_CHECK_EN
      // Returned count off by one after LOAD 10: sticky error CHK_LAT cycles later
      chk_skip  = 1'b1;
      cnt_fault = 1'b1;
      send(2'b00, 8'h10, 8'd0, 0);
      chk1("chkerr_load_cycle", chk_err, 1'b0);
      @(negedge clk);
      chk1("chkerr_compare_cycle", chk_err, 1'b0);
      @(negedge clk);
      chk1("chkerr_rises", chk_err, 1'b1);
      cnt_fault = 1'b0;
      wait_idle();
      run_cmd(2'b01, 8'h00, 8'd2);
      chk1("chkerr_sticky", chk_err, 1'b1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk1("chkerr_cleared", chk_err, 1'b0);
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      exp_cnt  = 8'h00;
      @(negedge clk);
      chk_skip = 1'b0;
      run_cmd(2'b11, 8'h20, 8'd2);
      chk1("chkerr_clean_after", chk_err, 1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cntr8_drv.md
# cntr8_drv

Command-driven stimulus and control engine for the 8-bit load/up/down counter (`cntr8`). It accepts high-level commands over a valid/ready handshake and turns each into a registered, cycle-exact sequence on the counter's `load`, `inc` and `d_in` inputs. It also raises a completion pulse. An optional shadow model checks the counter's returned count against the expected value. It sits between a test/control master and `cntr8`, driving the same `load`/`inc` interface that `ns_logic` decodes.

## Interface
- `CHK_LAT`, 1: cycles from a driven cycle to when `cnt_in` reflects it. Range 1–4; only used with the check feature.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_op` in 2: 00 LOAD, 01 UP, 10 DOWN, 11 LOAD_UP.
- `cmd_data` in 8: load value.
- `cmd_len` in 8: number of count steps; 0 means none.
- `load` out 1: to `cntr8.load`.
- `inc` out 1: to `cntr8.inc`.
- `d_in` out 8: to `cntr8.d_in`.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle pulse at command completion.
- `cnt_in` in 8: counter output, fed back.
- `chk_err` out 1: sticky mismatch flag.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Encoding lives in the package.
- IDLE:
  - `cmd_ready=1`.
  - A handshake (`cmd_valid & cmd_ready`) latches op, data and len.
  - Next state is LOAD for LOAD or LOAD_UP.
  - Next state is RUN for UP or DOWN with len≠0.
  - Next state is DONE for UP or DOWN with len=0.
- LOAD:
  - Outputs `load=1`, `d_in=data`, `inc=0`. Lasts one cycle.
  - Next state is RUN if op=LOAD_UP and len≠0, else DONE.
- RUN:
  - Outputs `load=0`, `inc=1` for UP/LOAD_UP, `inc=0` for DOWN.
  - An 8-bit step counter preloaded with len decrements each cycle.
  - Leaves for DONE in the cycle it reads 1.
- DONE: `done=1` for one cycle, then IDLE.
- `cmd_ready=0` in every state except IDLE. Commands presented while busy are held off, not dropped.
- `busy=1` in LOAD, RUN and DONE.
- `load`, `inc` and `d_in` are registered outputs. Outside LOAD/RUN they are 0.
- Wrap-around is not the driver's concern. The counter wraps 8'hFF→8'h00 on up and 8'h00→8'hFF on down. The shadow model is mod-256.
- Reset is honoured mid-command. On `reset_n` low:
  - Immediately go to IDLE and clear all outputs.
  - The in-flight command is abandoned, with no `done`.
  - `chk_err` is cleared.

## Timing
- Reset values: `cmd_ready=1`, `busy=0`, `done=0`, `load=0`, `inc=0`, `d_in=8'h00`, `chk_err=0`.
- Handshake at rising edge k:
  - First driven cycle is k+1.
  - LOAD: `load` is high in cycle k+1; `done` in k+2; `cmd_ready` returns in k+3.
  - UP/DOWN with len=N≥1: `inc` pattern in cycles k+1..k+N; `done` in k+N+1.
  - LOAD_UP with len=N: load in k+1, up steps in k+2..k+N+1, `done` in k+N+2.
  - UP/DOWN with len=0: `done` in k+1 and no counter activity.
- Back-to-back commands: there is a minimum one IDLE cycle between `done` and the next first driven cycle.

## Configuration
- `CNTR8_DRV_CHECK_EN` defined:
  - An 8-bit shadow count is set to data on a LOAD cycle, +1 per UP step and −1 per DOWN step.
  - A CHK_LAT-deep pipeline of (expected, valid) compares against `cnt_in` only for driven cycles.
  - A mismatch sets `chk_err`, which stays set until reset.
- Not defined: shadow model and pipeline are absent, `chk_err` is tied 0, and `cnt_in` is unused.

## Structure
- Package `cntr8_pkg`:
  - FSM state typedef.
  - Op codes `OP_LOAD`/`OP_UP`/`OP_DOWN`/`OP_LOAD_UP`.
  - Data width constant 8.
- One sub-module `cntr8_drv_chk` holds the shadow model, delay pipeline and comparator. It is instantiated only under `CNTR8_DRV_CHECK_EN`.

## Test plan
- Reset mid-RUN (UP, len=10, `reset_n` low at step 4): outputs go to reset values asynchronously; no `done`; `cmd_ready=1` after release.
- LOAD `data=8'h5A`: `load=1` and `d_in=8'h5A` for exactly one cycle; `done` the next cycle; `cnt_in` later reads 8'h5A.
- LOAD_UP `data=8'hFE`, len=3: load cycle, then 3 `inc=1` cycles; `done` at k+5; counter reads 8'h01 (wrap); `chk_err=0`.
- DOWN `data` ignored, len=0: `done` at k+1; `load=inc=0` throughout.
- Back-to-back: `cmd_valid` held high with UP len=2 then DOWN len=2; the second handshake occurs only after `done`; the `inc` sequence is 1,1 then 0,0.
- With `CNTR8_DRV_CHECK_EN`: force `cnt_in` off by one after a LOAD of 8'h10 → `chk_err` rises after CHK_LAT cycles and stays 1 until reset.
